// File: rtl/hazard_stall_unit.sv
// ID-stage hazard controller: load-use stalls, taken-branch flushes, HALT drain/freeze
// and a saturating count of load-use stall cycles.
//
// state  | meaning
// RUN    | normal issue; load-use stalls, branch flushes, HALT starts the drain
// DRAIN  | HALT travelling EX..WB; front end frozen, bubbles into ID/EX
// HALTED | pipeline drained and frozen until reset
module hazard_stall_unit #(
  parameter int BITS_REGS    = 5,
  parameter int BITS_COUNT   = 32,
  parameter int DRAIN_CYCLES = 3,
  parameter int BITS_DRAIN   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_IDEX_mem_read,
  input  logic [BITS_REGS-1:0]  i_IDEX_rt,
  input  logic [BITS_REGS-1:0]  i_IFID_rs,
  input  logic [BITS_REGS-1:0]  i_IFID_rt,
  input  logic                  i_branch_taken,
  input  logic                  i_halt_id,
  output logic                  o_pc_write,
  output logic                  o_ifid_write,
  output logic                  o_ifid_flush,
  output logic                  o_idex_bubble,
  output logic                  o_halted,
  output logic [BITS_COUNT-1:0] o_stall_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                state;
  logic [BITS_DRAIN-1:0] drain_cnt;
  logic                  load_use;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = i_IDEX_mem_read && (i_IDEX_rt != '0) &&
                    ((i_IDEX_rt == i_IFID_rs) || (i_IDEX_rt == i_IFID_rt));

  always_comb begin
    o_pc_write    = 1'b0;
    o_ifid_write  = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    if (i_rst_n && i_enable) begin
      case (state)
        RUN: begin
          if (load_use) begin
            o_idex_bubble = 1'b1;
          end else if (i_branch_taken) begin
            o_pc_write   = 1'b1;
            o_ifid_write = 1'b1;
            o_ifid_flush = 1'b1;
          end else if (!i_halt_id) begin
            o_pc_write   = 1'b1;
            o_ifid_write = 1'b1;
          end
        end
        DRAIN, HALTED: o_idex_bubble = 1'b1;
        default: o_idex_bubble = 1'b1;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= RUN;
      drain_cnt     <= '0;
      o_halted      <= 1'b0;
      o_stall_count <= '0;
    end else if (i_enable) begin
      case (state)
        RUN: begin
          if (load_use) begin
            if (o_stall_count != '1)
              o_stall_count <= o_stall_count + 1'b1;
          end else if (!i_branch_taken && i_halt_id) begin
            state     <= DRAIN;
            drain_cnt <= BITS_DRAIN'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - 1'b1;
          // Count value 1 marks the cycle HALT retires from WB.
          if (drain_cnt == BITS_DRAIN'(1)) begin
            state    <= HALTED;
            o_halted <= 1'b1;
          end
        end
        HALTED: state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

endmodule
